uart_rx_os16: RTL and testbench
===============================

UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 Parameter: none; all configuration arrives on ports.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low; sampled on clk rising edge.
REQ-004 serial  in  1  asynchronous UART line, idle high.
REQ-005 baudRate  in  3  rate select; oversample tick every 2^(7-baudRate) clk cycles (7 = fastest, tick every cycle).
REQ-006 parity  in  2  0 = none, 1 = odd, 2 = even, 3 = none.
REQ-007 ready  in  1  consumer accepts data when ready && valid.
REQ-008 data  out  8  received byte, LSB received first.
REQ-009 valid  out  1  data/parityError/frameError hold a byte.
REQ-010 parityError  out  1  parity mismatch for the held byte.
REQ-011 frameError  out  1  stop bit sampled low for the held byte.
REQ-012 overrun  out  1  one-cycle pulse: a completed byte was dropped.
REQ-013 busy  out  1  high in every state except IDLE.

Function
REQ-014 serial passes through a 2-flop synchronizer before any use; a start edge is synchronized serial high-to-low.
REQ-015 Tick generator: free-running counter, 16 ticks per bit, tick period per REQ-005; counter restarts on start-edge detection.
REQ-016 States: IDLE, START, DATA, PARITY, STOP; encoding is free.
REQ-017 IDLE -> START on start edge; baudRate and parity are latched at that edge, and later changes are ignored until the next IDLE.
REQ-018 START: sample at tick 7 (mid-bit); low -> DATA; high -> IDLE (false start, no output).
REQ-019 DATA: sample every 16 ticks after the mid-start sample; 8 bits, shifted LSB first; after bit 7 -> PARITY if the latched parity is 1 or 2, else -> STOP.
REQ-020 PARITY: sample once at mid-bit; odd parity: error if XOR(data bits, parity bit) != 1; even parity: error if XOR != 0.
REQ-021 STOP: sample once at mid-bit; low sets frameError for that byte; always -> IDLE on the next cycle, without waiting for the line to go high.
REQ-022 After a low stop bit, a new start edge is detected only after serial returns high (edge rule of REQ-014).
REQ-023 Byte completion = cycle after the stop sample: if valid is low, or ready && valid in the same cycle, load data/parityError/frameError and set valid.
REQ-024 If valid && !ready at completion, the held byte is kept, the new byte is discarded, and overrun pulses high for exactly one cycle.
REQ-025 valid clears on the cycle after ready && valid unless it is reloaded per REQ-023 in that cycle.
REQ-026 data, parityError and frameError remain stable while valid is high and ready is low.
REQ-027 Latency at baudRate=7: valid rises 8 + 16*N + 1 cycles after start-edge detection, where N = 9 (no parity) or 10 (parity).

Reset
REQ-028 reset low at any clock edge: state IDLE; tick counter, shift register and data = 0; valid, parityError, frameError, overrun and busy = 0; synchronizer flops = 1.
REQ-029 reset low mid-frame abandons the frame with no output; reception resumes only on a fresh start edge after reset goes high.
REQ-030 reset overrides ready and any completion in the same cycle.

Verification
REQ-031 baudRate=7, parity=0, frame 0x55 with stop=1, ready=1 -> data=0x55, valid high for 1 cycle at latency 153, both errors 0.
REQ-032 parity=1 (odd), byte 0xA3 with parity bit 1 -> parityError=0; same byte with parity bit 0 -> parityError=1, data=0xA3.
REQ-033 parity=2 (even), byte 0x00 with stop bit 0 -> data=0x00, frameError=1, parityError=0; next frame 0x7E is received only after the line returns high.
REQ-034 A 4-cycle low glitch on serial (baudRate=7) -> START returns to IDLE, valid stays 0, busy drops within 10 cycles.
REQ-035 ready=0; frames 0x11 then 0x22 -> data holds 0x11, overrun pulses once at the second completion; ready=1 -> valid drops and 0x22 is never presented.
REQ-036 reset low during DATA bit 4 of 0xF0 -> outputs reset per REQ-028; a full 0x3C frame after release -> data=0x3C.

Source files
------------

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver: runtime rate/parity select, mid-bit sampling,
// optional parity check and a single-entry ready/valid output register.
module uart_rx_os16 (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial,
  input  logic [2:0] baudRate,
  input  logic [1:0] parity,
  input  logic       ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       parityError,
  output logic       frameError,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t state_q, state_d;

  logic       sync1_q, sync2_q, sync3_q;
  logic [6:0] div_q, div_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] baud_q, baud_d;
  logic [1:0] par_q, par_d;
  logic       frm_perr_q, frm_perr_d;
  logic       frm_ferr_q, frm_ferr_d;
  logic       done_q, done_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;

  logic [6:0] tick_mask;
  logic       tick, sample, start_edge, par_en;
  logic       shift_en, par_smp, stop_smp;

  assign start_edge = sync3_q & ~sync2_q;
  // Tick period is 2^(7-baud); the mask selects the low divider bits that wrap.
  assign tick_mask  = 7'h7F >> baud_q;
  assign tick       = (div_q & tick_mask) == tick_mask;
  assign sample     = tick && (cnt_q == 4'd7);
  assign par_en     = (par_q == 2'd1) || (par_q == 2'd2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_edge) state_d = S_START;
      S_START:  if (sample) state_d = sync2_q ? S_IDLE : S_DATA;
      S_DATA:   if (sample && (bit_q == 3'd7)) state_d = par_en ? S_PARITY : S_STOP;
      S_PARITY: if (sample) state_d = S_STOP;
      S_STOP:   if (sample) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = 1'b1;
    shift_en = 1'b0;
    par_smp  = 1'b0;
    stop_smp = 1'b0;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_DATA:   shift_en = sample;
      S_PARITY: par_smp = sample;
      S_STOP:   stop_smp = sample;
      default:  ;
    endcase
  end

  always_comb begin
    div_d      = div_q + 7'd1;
    cnt_d      = tick ? cnt_q + 4'd1 : cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    baud_d     = baud_q;
    par_d      = par_q;
    frm_perr_d = frm_perr_q;
    frm_ferr_d = frm_ferr_q;
    done_d     = stop_smp;

    if ((state_q == S_IDLE) && start_edge) begin
      div_d      = 7'd0;
      cnt_d      = 4'd0;
      bit_d      = 3'd0;
      baud_d     = baudRate;
      par_d      = parity;
      frm_perr_d = 1'b0;
    end
    if (shift_en) begin
      shift_d = {sync2_q, shift_q[7:1]};
      bit_d   = bit_q + 3'd1;
    end
    // XOR of data and parity bit must be 1 for odd, 0 for even.
    if (par_smp) frm_perr_d = (^shift_q) ^ sync2_q ^ (par_q == 2'd1);
    if (stop_smp) frm_ferr_d = ~sync2_q;

    data_d  = data_q;
    valid_d = valid_q && !ready;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (done_q) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        perr_d  = frm_perr_q;
        ferr_d  = frm_ferr_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      sync3_q    <= 1'b1;
      div_q      <= 7'd0;
      cnt_q      <= 4'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      baud_q     <= 3'd0;
      par_q      <= 2'd0;
      frm_perr_q <= 1'b0;
      frm_ferr_q <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= serial;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      baud_q     <= baud_d;
      par_q      <= par_d;
      frm_perr_q <= frm_perr_d;
      frm_ferr_q <= frm_ferr_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign parityError = perr_q;
  assign frameError  = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: vector table, hand-written corner
// sequences and randomized frames checked against a bit-level frame model.
module tb_uart_rx_os16;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial;
  logic [2:0] baudRate;
  logic [1:0] parity;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       parityError;
  logic       frameError;
  logic       overrun;
  logic       busy;

  uart_rx_os16 dut (
    .clk(clk), .reset(reset), .serial(serial), .baudRate(baudRate),
    .parity(parity), .ready(ready), .data(data), .valid(valid),
    .parityError(parityError), .frameError(frameError),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rx_t;

  rx_t acc_q[$];
  int  rise_q[$];
  int  ovr_cnt = 0;
  int  ovr_cyc = -1;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Observer: records valid rises, accepted bytes and overrun pulses, and
  // checks that a held byte does not move while the consumer stalls.
  logic valid_prev = 1'b0;
  logic hold_prev = 1'b0;
  rx_t  held_prev;
  always @(negedge clk) begin
    if (reset) begin
      if (valid && !valid_prev) rise_q.push_back(cyc);
      if (valid && ready) acc_q.push_back({data, parityError, frameError});
      if (overrun) begin
        ovr_cnt++;
        ovr_cyc = cyc;
      end
      if (hold_prev) check("hold_stable", {valid, data, parityError, frameError},
                           {1'b1, held_prev});
    end
    valid_prev = reset && valid;
    hold_prev  = reset && valid && !ready;
    held_prev  = {data, parityError, frameError};
  end

  task automatic drive_bit(input logic b, input int per);
    serial = b;
    repeat (16 * per) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [2:0] b, input logic [1:0] p, input logic [7:0] d,
                            input logic pb, input logic st, input bit scramble,
                            output int t0);
    int per;
    per = 1 << (7 - b);
    baudRate = b;
    parity = p;
    t0 = cyc;
    drive_bit(1'b0, per);
    if (scramble) begin
      baudRate = 3'($urandom);
      parity = 2'($urandom);
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], per);
    if (p == 2'd1 || p == 2'd2) drive_bit(pb, per);
    drive_bit(st, per);
  endtask

  // Frame model: 2 sync flops + edge register before START, then the stop
  // sample lands 8+16*N ticks later and valid follows one cycle after that.
  function automatic int exp_rise(input int t0, input logic [2:0] b, input logic [1:0] p);
    int nb;
    nb = (p == 2'd1 || p == 2'd2) ? 10 : 9;
    return t0 + 3 + (1 << (7 - b)) * (8 + 16 * nb) + 1;
  endfunction

  task automatic expect_frame(input string nm, input logic [7:0] ed, input logic ep,
                              input logic ef, input int erise);
    rx_t r;
    check({nm, "_nrise"}, rise_q.size(), 1);
    if (rise_q.size() > 0) check({nm, "_latency"}, rise_q.pop_front(), erise);
    check({nm, "_nacc"}, acc_q.size(), 1);
    if (acc_q.size() > 0) begin
      r = acc_q.pop_front();
      check({nm, "_data"}, r.d, ed);
      check({nm, "_perr"}, r.pe, ep);
      check({nm, "_ferr"}, r.fe, ef);
    end
    rise_q.delete();
    acc_q.delete();
  endtask

  typedef struct {
    logic [2:0] baud;
    logic [1:0] par;
    logic [7:0] byte_v;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t0, t1, last, saw, busy_seen, per;
    logic [2:0] b;
    logic [1:0] p;
    logic [7:0] d;
    logic pb, st, x, ep;

    vecs[0] = '{3'd7, 2'd0, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1] = '{3'd7, 2'd1, 8'hA3, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[2] = '{3'd7, 2'd1, 8'hA3, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b0};
    vecs[3] = '{3'd6, 2'd2, 8'hC4, 1'b1, 1'b1, 8'hC4, 1'b0, 1'b0};
    vecs[4] = '{3'd6, 2'd2, 8'hC4, 1'b0, 1'b1, 8'hC4, 1'b1, 1'b0};
    vecs[5] = '{3'd5, 2'd3, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[6] = '{3'd7, 2'd0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};
    vecs[7] = '{3'd7, 2'd1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};

    reset = 1'b0;
    serial = 1'b1;
    baudRate = 3'd7;
    parity = 2'd0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_perr", parityError, 0);
    check("rst_ferr", frameError, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].baud, vecs[i].par, vecs[i].byte_v, vecs[i].pbit, vecs[i].stop, 1'b0, t0);
      serial = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      expect_frame($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr,
                   vecs[i].exp_ferr, exp_rise(t0, vecs[i].baud, vecs[i].par));
      $display("vec%0d byte=%02h par=%0d baud=%0d done", i, vecs[i].byte_v, vecs[i].par, vecs[i].baud);
    end

    // Low stop bit with the line left low: no new frame until it goes high.
    send_frame(3'd7, 2'd2, 8'h00, 1'b0, 1'b0, 1'b0, t0);
    busy_seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    check("lowstop_busy_cycles", busy_seen, 0);
    @(posedge clk);
    #1;
    expect_frame("lowstop", 8'h00, 1'b0, 1'b1, exp_rise(t0, 3'd7, 2'd2));
    serial = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    send_frame(3'd7, 2'd2, 8'h7E, 1'b0, 1'b1, 1'b0, t0);
    serial = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    expect_frame("after_low", 8'h7E, 1'b0, 1'b0, exp_rise(t0, 3'd7, 2'd2));
    $display("low stop bit sequence done");

    // Short glitch: false start, nothing presented.
    baudRate = 3'd7;
    parity = 2'd0;
    t0 = cyc;
    serial = 1'b0;
    repeat (4) @(posedge clk);
    #1 serial = 1'b1;
    saw = 0;
    last = t0;
    repeat (40) begin
      @(negedge clk);
      if (busy) begin
        saw = 1;
        last = cyc;
      end
    end
    check("glitch_busy_seen", saw, 1);
    check("glitch_busy_drop_in_10", int'((last - (t0 + 3)) < 10), 1);
    check("glitch_nrise", rise_q.size(), 0);
    check("glitch_nacc", acc_q.size(), 0);
    $display("glitch sequence done busy_last=%0d", last - t0);
    @(posedge clk);
    #1;

    // Stalled consumer: second byte dropped with a single overrun pulse.
    ready = 1'b0;
    ovr_cnt = 0;
    rise_q.delete();
    acc_q.delete();
    send_frame(3'd7, 2'd0, 8'h11, 1'b0, 1'b1, 1'b0, t0);
    serial = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send_frame(3'd7, 2'd0, 8'h22, 1'b0, 1'b1, 1'b0, t1);
    serial = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("ovr_valid_held", valid, 1);
    check("ovr_data_held", data, 8'h11);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_when", ovr_cyc, exp_rise(t1, 3'd7, 2'd0));
    ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_drop", valid, 0);
    repeat (20) @(posedge clk);
    #1;
    expect_frame("ovr", 8'h11, 1'b0, 1'b0, exp_rise(t0, 3'd7, 2'd0));
    $display("overrun sequence done pulses=%0d", ovr_cnt);

    // Reset in the middle of data bit 4 of 0xF0.
    baudRate = 3'd7;
    parity = 2'd0;
    drive_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1);
    serial = 1'b1;
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_data", data, 0);
    check("midrst_valid", valid, 0);
    check("midrst_perr", parityError, 0);
    check("midrst_ferr", frameError, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_busy", busy, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (200) @(posedge clk);
    #1;
    check("midrst_nrise", rise_q.size(), 0);
    send_frame(3'd7, 2'd0, 8'h3C, 1'b0, 1'b1, 1'b0, t0);
    serial = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    expect_frame("midrst_next", 8'h3C, 1'b0, 1'b0, exp_rise(t0, 3'd7, 2'd0));
    $display("mid-frame reset sequence done");

    // Randomized frames, rate/parity inputs scrambled after the start bit.
    for (int k = 0; k < 24; k++) begin
      b = 3'($urandom_range(5, 7));
      p = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 5) != 0);
      x = 1'(($countones(d) + int'(pb)) % 2);
      ep = (p == 2'd1) ? !x : (p == 2'd2) ? x : 1'b0;
      send_frame(b, p, d, pb, st, 1'b1, t0);
      serial = 1'b1;
      per = 20 + $urandom_range(0, 15);
      repeat (per) @(posedge clk);
      #1;
      expect_frame($sformatf("rnd%0d", k), d, ep, !st, exp_rise(t0, b, p));
      $display("rnd%0d byte=%02h baud=%0d par=%0d pbit=%0d stop=%0d", k, d, b, p, pb, st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
